// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the fetch stage, its bus interface and
// the decoder side.
//   fetch_state_t : fetch sequencer states (IDLE, FETCH, ISSUE)
//   INSTR_W       : instruction word width
//   PC_W          : program counter / instruction address width; it matches
//                   the 8-bit jump immediate
//   INSTR_NOP     : word shown to the decoder whenever nothing is issued
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 8;

  localparam logic [INSTR_W-1:0] INSTR_NOP = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bus between the fetch stage, instruction memory, the
// decoder and the branch-condition logic.
//
// Handshakes (both use strict valid/ready-style semantics):
//   - Memory side: imem_req is held high with imem_addr stable until a
//     cycle in which imem_valid=1. That cycle transfers imem_rdata.
//     imem_valid is ignored while imem_req=0.
//   - Decoder side: instr_valid is held high with instr stable until a
//     cycle in which instr_ready=1. That cycle retires the instruction.
//     br_taken/br_target are sampled only in that same cycle.
//
// Modports:
//   master : the fetch unit (drives req/addr/instr/instr_valid)
//   slave  : memory + decoder + branch logic
interface fetch_unit_if;
  import cpu_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_valid;

  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;

  logic               br_taken;
  logic [PC_W-1:0]    br_target;

  modport master (
    output imem_req, imem_addr, instr, instr_valid,
    input  imem_rdata, imem_valid, instr_ready, br_taken, br_target
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid,
    output imem_rdata, imem_valid, instr_ready, br_taken, br_target
  );

endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage upstream of the decoder.
//
// Holds the program counter and fetches one 16-bit instruction at a time.
// It requests the word from instruction memory, latches it into ir, and
// then presents it to the decoder until it is accepted. On acceptance, a
// taken jump redirects pc to the jump target. Otherwise pc advances by
// one and wraps.
//
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   run        : level, fetch continuously while high
//   step       : one-cycle pulse, fetch exactly one instruction from IDLE
//   bus        : fetch_unit_if.master (memory + decoder + branch signals)
//   pc         : current program counter (equals bus.imem_addr)
//   retired    : count of accepted instructions, wraps at 2^CNT_W
//   busy       : high whenever the sequencer is not IDLE
//   dbg_state  : current sequencer state
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step,
  fetch_unit_if.master     bus,
  output logic [PC_W-1:0]  pc,
  output logic [CNT_W-1:0] retired,
  output logic             busy,
  output fetch_state_t     dbg_state
);

  fetch_state_t       state_q,   state_d;
  logic [PC_W-1:0]    pc_q,      pc_d;
  logic [INSTR_W-1:0] ir_q,      ir_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    unique case (state_q)
      IDLE: begin
        if (run || step) state_d = FETCH;
      end
      FETCH: begin
        // Each fetch runs to completion. A run drop or a step pulse here
        // has no effect until the instruction retires.
        if (bus.imem_valid) begin
          ir_d    = bus.imem_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.instr_ready) begin
          pc_d      = bus.br_taken ? bus.br_target : pc_q + PC_W'(1);
          retired_d = retired_q + CNT_W'(1);
          state_d   = run ? FETCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      ir_q      <= INSTR_NOP;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  // All outputs decode registered state only, so they move only on clock
  // edges or on reset. Forcing NOP outside ISSUE keeps the combinational
  // decoder from acting on a stale ir.
  assign bus.imem_req    = (state_q == FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (state_q == ISSUE);
  assign bus.instr       = (state_q == ISSUE) ? ir_q : INSTR_NOP;

  assign pc        = pc_q;
  assign retired   = retired_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit.
// Main instance (dut) has CNT_W=16 and is fed by a memory model with a
// programmable wait count. The word at address a is 16'h0041 + a. A second
// instance (dut_w) with CNT_W=3 free-runs against a zero-wait memory to
// show the retired counter wrapping.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic run, step;
  logic run_w;
  int   mem_wait;

  logic [PC_W-1:0] pc_a, pc_w;
  logic [15:0]     retired_a;
  logic [2:0]      retired_w;
  logic            busy_a, busy_w;
  fetch_state_t    state_a, state_w;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit_if bus_a ();
  fetch_unit_if bus_w ();

  fetch_unit #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .bus(bus_a.master),
    .pc(pc_a), .retired(retired_a), .busy(busy_a), .dbg_state(state_a)
  );

  fetch_unit #(.CNT_W(3)) dut_w (
    .clk(clk), .rst_n(rst_n), .run(run_w), .step(1'b0), .bus(bus_w.master),
    .pc(pc_w), .retired(retired_w), .busy(busy_w), .dbg_state(state_w)
  );

  // Zero-wait memory and an always-ready decoder for the wrap instance.
  assign bus_w.imem_valid  = bus_w.imem_req;
  assign bus_w.imem_rdata  = 16'h1234;
  assign bus_w.instr_ready = 1'b1;
  assign bus_w.br_taken    = 1'b0;
  assign bus_w.br_target   = '0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- memory driver ----------------
  // Decides imem_valid on each falling edge from the request that the DUT
  // currently shows. mem_wait sets how many empty cycles come first.
  initial begin : mem_model
    int cnt;
    cnt = 0;
    bus_a.imem_valid = 1'b0;
    bus_a.imem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (!rst_n || !bus_a.imem_req) begin
        cnt = 0;
        bus_a.imem_valid = 1'b0;
      end else if (cnt < mem_wait) begin
        cnt++;
        bus_a.imem_valid = 1'b0;
      end else begin
        cnt = 0;
        bus_a.imem_valid = 1'b1;
        bus_a.imem_rdata = 16'h0041 + {8'h00, bus_a.imem_addr};
      end
    end
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    bit found;
    rst_n = 1'b0; run = 1'b0; step = 1'b0; run_w = 1'b0; mem_wait = 0;
    bus_a.instr_ready = 1'b0; bus_a.br_taken = 1'b0; bus_a.br_target = 8'h00;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_state", 32'(state_a), 32'(IDLE));
    chk("rst_pc", 32'(pc_a), 32'h0);
    chk("rst_req", 32'(bus_a.imem_req), 32'h0);
    chk("rst_addr", 32'(bus_a.imem_addr), 32'h0);
    chk("rst_instr", 32'(bus_a.instr), 32'h0);
    chk("rst_valid", 32'(bus_a.instr_valid), 32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);
    chk("rst_retired", 32'(retired_a), 32'h0);

    // Free run, zero-wait memory, decoder always ready
    rst_n = 1'b1; run = 1'b1; bus_a.instr_ready = 1'b1;
    @(negedge clk);
    chk("run_fetch_state", 32'(state_a), 32'(FETCH));
    chk("run_req", 32'(bus_a.imem_req), 32'h1);
    chk("run_addr0", 32'(bus_a.imem_addr), 32'h00);
    chk("run_nop_in_fetch", 32'(bus_a.instr), 32'h0000);
    @(negedge clk);
    chk("run_instr0", 32'(bus_a.instr), 32'h0041);
    chk("run_valid0", 32'(bus_a.instr_valid), 32'h1);
    chk("run_pc0", 32'(pc_a), 32'h00);
    @(negedge clk);
    chk("run_addr1", 32'(bus_a.imem_addr), 32'h01);
    chk("run_retired1", 32'(retired_a), 32'h1);
    chk("run_nop_fetch1", 32'(bus_a.instr), 32'h0000);
    @(negedge clk);
    chk("run_instr1", 32'(bus_a.instr), 32'h0042);
    run = 1'b0;
    @(negedge clk);
    chk("run_pc2", 32'(pc_a), 32'h02);
    chk("run_retired2", 32'(retired_a), 32'h2);
    chk("run_idle", 32'(state_a), 32'(IDLE));
    chk("run_busy_idle", 32'(busy_a), 32'h0);

    // Single step; second step during ISSUE is ignored
    bus_a.instr_ready = 1'b0; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("step_fetch", 32'(state_a), 32'(FETCH));
    chk("step_addr", 32'(bus_a.imem_addr), 32'h02);
    @(negedge clk);
    chk("step_instr", 32'(bus_a.instr), 32'h0043);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("step_hold_issue", 32'(state_a), 32'(ISSUE));
    chk("step_hold_instr", 32'(bus_a.instr), 32'h0043);
    bus_a.instr_ready = 1'b1;
    @(negedge clk);
    bus_a.instr_ready = 1'b0;
    chk("step_back_idle", 32'(state_a), 32'(IDLE));
    chk("step_pc", 32'(pc_a), 32'h03);
    chk("step_retired", 32'(retired_a), 32'h3);
    @(negedge clk);
    chk("step_not_queued", 32'(state_a), 32'(IDLE));

    // Jump redirect; br_taken without handshake has no effect
    run = 1'b1; bus_a.br_taken = 1'b1; bus_a.br_target = 8'h20;
    @(negedge clk);
    chk("br_fetch_addr3", 32'(bus_a.imem_addr), 32'h03);
    @(negedge clk);
    chk("br_instr", 32'(bus_a.instr), 32'h0044);
    @(negedge clk);
    chk("br_no_hs_pc", 32'(pc_a), 32'h03);
    chk("br_no_hs_state", 32'(state_a), 32'(ISSUE));
    bus_a.instr_ready = 1'b1;
    @(negedge clk);
    chk("br_target_addr", 32'(bus_a.imem_addr), 32'h20);
    chk("br_retired", 32'(retired_a), 32'h4);
    bus_a.br_target = 8'hFF;
    @(negedge clk);
    chk("br_instr_at20", 32'(bus_a.instr), 32'h0061);
    @(negedge clk);
    chk("br_addr_ff", 32'(bus_a.imem_addr), 32'hFF);
    chk("br_retired5", 32'(retired_a), 32'h5);
    bus_a.br_taken = 1'b0; run = 1'b0;
    @(negedge clk);
    chk("br_instr_atff", 32'(bus_a.instr), 32'h0140);
    @(negedge clk);
    chk("pc_wrap", 32'(pc_a), 32'h00);
    chk("pc_wrap_retired", 32'(retired_a), 32'h6);
    chk("pc_wrap_idle", 32'(state_a), 32'(IDLE));
    bus_a.instr_ready = 1'b0;

    // Memory wait states and downstream stall
    mem_wait = 3; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wait_req_%0d", i), 32'(bus_a.imem_req), 32'h1);
      chk($sformatf("wait_addr_%0d", i), 32'(bus_a.imem_addr), 32'h00);
      chk($sformatf("wait_nop_%0d", i), 32'(bus_a.instr), 32'h0000);
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("stall_instr_%0d", i), 32'(bus_a.instr), 32'h0041);
      chk($sformatf("stall_valid_%0d", i), 32'(bus_a.instr_valid), 32'h1);
      @(negedge clk);
    end
    chk("stall_still_issue", 32'(state_a), 32'(ISSUE));
    bus_a.instr_ready = 1'b1;
    @(negedge clk);
    bus_a.instr_ready = 1'b0; mem_wait = 0;
    chk("stall_pc", 32'(pc_a), 32'h01);
    chk("stall_retired", 32'(retired_a), 32'h7);

    // Reset during ISSUE aborts immediately
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    chk("abort_pre_valid", 32'(bus_a.instr_valid), 32'h1);
    chk("abort_pre_instr", 32'(bus_a.instr), 32'h0042);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(bus_a.instr_valid), 32'h0);
    chk("abort_instr", 32'(bus_a.instr), 32'h0000);
    chk("abort_pc", 32'(pc_a), 32'h00);
    chk("abort_retired", 32'(retired_a), 32'h0);
    chk("abort_busy", 32'(busy_a), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Retired counter wrap on the narrow instance
    run_w = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (retired_w == 3'd7 && bus_w.instr_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("wrap_reached_7", 32'(found), 32'h1);
    @(negedge clk);
    chk("wrap_retired_0", 32'(retired_w), 32'h0);
    chk("wrap_pc_8", 32'(pc_w), 32'h08);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the instruction decoder. Holds the 8-bit program counter and drives a request/valid handshake to instruction memory. Latches each 16-bit instruction and presents it to the decoder under an instr_valid/instr_ready handshake. Applies jump redirects (8-bit immediate targets) reported by the branch-condition logic at retire, and supports free-run and single-step modes for lab use.

## Interface
- PC_W, 8, program counter / instruction address width (matches the 8-bit jump immediate)
- CNT_W, 16, width of retired-instruction counter
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous and active-low
- run  in  1  level; 1 = fetch continuously
- step  in  1  one-cycle pulse; fetch exactly one instruction when idle
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  PC_W  fetch address (= pc)
- imem_rdata  in  16  instruction word from memory
- imem_valid  in  1  imem_rdata valid this cycle
- instr  out  16  instruction to decoder; 16'h0000 (NOP) whenever instr_valid=0
- instr_valid  out  1  instr holds a fetched instruction
- instr_ready  in  1  downstream accepts/retires instr this cycle
- br_taken  in  1  retiring instruction is a taken jump (sampled only at handshake)
- br_target  in  PC_W  jump target (sampled only at handshake)
- pc  out  PC_W  current program counter
- retired  out  CNT_W  count of accepted instructions
- busy  out  1  state != IDLE

## Operation
- States: IDLE, FETCH, ISSUE.
- IDLE: imem_req=0, instr_valid=0. Go to FETCH when run=1 or step=1.
- FETCH: imem_req=1, imem_addr=pc held stable. On imem_valid=1: ir <= imem_rdata, go to ISSUE. imem_valid outside FETCH is ignored.
- ISSUE: instr_valid=1, instr=ir. On instr_ready=1 (handshake):
  - pc <= br_taken ? br_target : pc+1 (mod 2^PC_W, 8'hFF+1 -> 8'h00).
  - retired <= retired+1, wraps at 2^CNT_W.
  - next state FETCH if run=1, else IDLE.
- step while FETCH/ISSUE is ignored (not queued). run dropping mid-fetch does not abort; the current instruction completes, then IDLE.
- br_taken/br_target ignored outside the ISSUE handshake cycle.
- NOP forcing guarantees the combinational decoder sees no write/show when nothing is issued.

## Timing
- Reset (async assert, sync deassert by board logic): state=IDLE, pc=0, ir=16'h0000, retired=0; outputs imem_req=0, imem_addr=0, instr=16'h0000, instr_valid=0, busy=0.
- Reset mid-fetch or mid-issue aborts immediately; no handshake is credited, pc returns to 0.
- All outputs derive from registered state; imem_addr, instr, pc change only on clk edges.
- Best case (imem_valid same cycle as req, instr_ready same cycle as valid): 2 cycles per instruction; IDLE->FETCH adds 1 cycle.
- Memory wait states stretch FETCH; no timeout. Downstream stalls stretch ISSUE with instr stable.
- pc and retired update on the edge following the handshake cycle; the new imem_addr appears in that same FETCH cycle.

## Structure
- Shared package cpu_pkg: fetch_state_t enum (IDLE, FETCH, ISSUE), INSTR_W=16, PC_W=8, INSTR_NOP=16'h0000.
- Single module, no sub-module; pc/next-pc logic and counter are inline.

## Test plan
- Reset then run=1, zero-wait memory returning 16'h0041 at 0, 16'h0042 at 1, instr_ready=1 -> instr 16'h0041 then 16'h0042 on alternate cycles, pc 0,1,2, retired=2 after 4 cycles.
- Assert step once from IDLE, run=0 -> exactly one instruction issued, pc=1, state back to IDLE; second step while ISSUE is ignored.
- Handshake with br_taken=1, br_target=8'h20 -> next imem_addr=8'h20; br_taken=1 while instr_ready=0 -> no redirect.
- pc=8'hFF, handshake with br_taken=0 -> pc=8'h00; retired preloaded near 16'hFFFF wraps to 0.
- imem_valid delayed 3 cycles and instr_ready held low 2 cycles -> imem_addr stable through FETCH, instr stable and instr_valid high through ISSUE, instr=16'h0000 in FETCH.
- Drop rst_n during ISSUE -> same-cycle instr_valid=0, instr=16'h0000, pc=0, retired unchanged by the aborted instruction (0).
